// File: rtl/config_stream_loader.sv
// Byte-serial configuration loader: assembles little-endian ADDR/DATA records
// from a valid/ready stream and issues each as a held write on the tile config bus.
module config_stream_loader #(
  parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] records_written
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_ISSUE = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] xor_q, xor_d;
  logic [15:0] n_q, n_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  hold_q, hold_d;
  logic [15:0] rec_q, rec_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_data_q, bus_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        collecting_s;
  logic        xfer_s;
  logic        word_done_s;
  logic [31:0] word_s;

  assign collecting_s = (state_q == S_HDR) || (state_q == S_ADDR) ||
                        (state_q == S_DATA) || (state_q == S_CHK);
  assign xfer_s       = in_valid && collecting_s;
  assign word_done_s  = xfer_s && (byte_idx_q == 2'd3);
  // Bytes enter at the top, so after four of them the first byte sits in [7:0].
  assign word_s       = {in_data, shift_q};

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    xor_d      = xor_q;
    n_d        = n_q;
    addr_d     = addr_q;
    data_d     = data_q;
    hold_d     = hold_q;
    rec_d      = rec_q;
    error_d    = error_q;

    if (xfer_s) begin
      shift_d    = word_s[31:8];
      byte_idx_d = byte_idx_q + 2'd1;
    end else begin
      shift_d    = shift_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_HDR;
          xor_d      = 32'd0;
          rec_d      = 16'd0;
          error_d    = 1'b0;
          byte_idx_d = 2'd0;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_HDR: begin
        if (word_done_s) begin
          xor_d   = xor_q ^ word_s;
          n_d     = word_s[15:0];
          state_d = (word_s[15:0] == 16'd0) ? S_CHK : S_ADDR;
        end else begin
          state_d = S_HDR;
        end
      end
      S_ADDR: begin
        if (word_done_s) begin
          xor_d   = xor_q ^ word_s;
          addr_d  = word_s;
          state_d = S_DATA;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_DATA: begin
        if (word_done_s) begin
          xor_d   = xor_q ^ word_s;
          data_d  = word_s;
          hold_d  = 4'd0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_ISSUE: begin
        if (hold_q == HOLD_LAST) begin
          rec_d   = rec_q + 16'd1;
          state_d = ((rec_q + 16'd1) == n_q) ? S_CHK : S_ADDR;
        end else begin
          hold_d  = hold_q + 4'd1;
        end
      end
      S_CHK: begin
        if (word_done_s) begin
          if (word_s == xor_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end else begin
          state_d = S_CHK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus and status are registered from the next state so they change only on edges.
    if (state_d == S_ISSUE) begin
      bus_addr_d = addr_d;
      bus_data_d = data_d;
    end else begin
      bus_addr_d = IDLE_ADDR;
      bus_data_d = 32'd0;
    end
    busy_d = (state_d == S_HDR) || (state_d == S_ADDR) || (state_d == S_DATA) ||
             (state_d == S_ISSUE) || (state_d == S_CHK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      shift_q    <= 24'd0;
      xor_q      <= 32'd0;
      n_q        <= 16'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      hold_q     <= 4'd0;
      rec_q      <= 16'd0;
      bus_addr_q <= IDLE_ADDR;
      bus_data_q <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      shift_q    <= shift_d;
      xor_q      <= xor_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hold_q     <= hold_d;
      rec_q      <= rec_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready        = collecting_s;
  assign config_addr     = bus_addr_q;
  assign config_data     = bus_data_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign records_written = rec_q;

endmodule

// File: doc/config_stream_loader.md
Name: config_stream_loader

Overview:
- Host-side producer of the tile configuration bus: the writer that drives config_addr/config_data into the PE tile array.
- Accepts a byte-serial bitstream over a valid/ready handshake, assembles 32-bit address/data records, and issues each one as a timed write on the broadcast configuration bus.
- Checks a trailing XOR checksum and reports busy/done/error status.
- Sits at the array top, between the external load interface and every tile's config_addr/config_data inputs.

Parameters:
- IDLE_ADDR, 32'hFFFF_FFFF, address driven whenever no write is active; section field 16'hFFFF decodes to no tile sub-block.
- HOLD_CYCLES, 1, cycles each write is held on the bus (1..15).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-low reset (asserted when rst==0, sampled on posedge clk)
- start  input  1  one-cycle pulse that begins a load; ignored while busy
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts a byte this cycle
- in_data  input  8  bitstream byte
- config_addr  output  32  bus address: [31:16] section, [15:0] tile id
- config_data  output  32  bus data
- busy  output  1  high from the cycle after start until DONE/ERR is entered
- done  output  1  one-cycle pulse when a load completes with a good checksum
- error  output  1  sticky; set on checksum mismatch; cleared by start or reset
- records_written  output  16  count of writes issued in the current load

Behaviour:
- Byte transfer: a byte moves only when in_valid && in_ready. Words are little-endian, 4 bytes each; the first accepted byte is [7:0].
- Stream format, in order:
  - COUNT word N; only [15:0] is used.
  - N records, each an ADDR word followed by a DATA word.
  - CHK word equal to the XOR of COUNT, every ADDR and every DATA word.
- States: IDLE, HDR, ADDR, DATA, ISSUE, CHK, DONE, ERR.
- Transitions:
  - IDLE --start--> HDR. Clear the XOR accumulator, records_written and error.
  - HDR: after 4 bytes, latch N. If N==0 go to CHK, else go to ADDR.
  - ADDR: after 4 bytes, go to DATA.
  - DATA: after 4 bytes, go to ISSUE.
  - ISSUE: drive the latched addr/data for exactly HOLD_CYCLES cycles, starting the cycle after the last DATA byte is accepted. On leaving, increment records_written. If records_written now equals N go to CHK, else go to ADDR.
  - CHK: after 4 bytes, compare with the accumulator. Match goes to DONE; mismatch goes to ERR.
  - DONE: done=1 for one cycle, then IDLE.
  - ERR: error=1 (sticky), then IDLE next cycle.
- in_ready is 1 only in HDR, ADDR, DATA and CHK. It is 0 in IDLE, ISSUE, DONE and ERR.
- Outside ISSUE: config_addr=IDLE_ADDR, config_data=0. The bus is registered, so there are no glitches between writes.
- Writes are issued as they arrive. A bad checksum does not retract writes already made; error informs the host.
- start is ignored in every state except IDLE, and in DONE/ERR.
- in_valid low stalls any collecting state indefinitely, with no timeout. The partial byte index is preserved across stalls.
- Reset values: in_ready=0, config_addr=IDLE_ADDR, config_data=0, busy=0, done=0, error=0, records_written=0, state=IDLE.
- Reset mid-operation (including mid-ISSUE) takes effect at the next edge: the bus returns to IDLE_ADDR and no further write is issued.
- records_written wraps at 16 bits; N is at most 65535, so wrap never occurs in a legal stream.
- Throughput with HOLD_CYCLES=1 and in_valid held high: one record per 9 cycles (8 byte cycles + 1 issue cycle).

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, then release. Required: config_addr=FFFF_FFFF, config_data=0, in_ready=0, busy=0, with no change for 20 cycles.
- Single record: start; stream COUNT=1, ADDR=0x0004_0003, DATA=0x0000_0002, CHK=0x0004_0000. Required: exactly one cycle of addr 0x00040003 / data 2, the cycle after the last DATA byte. done pulses after CHK; records_written=1; error=0.
- Three records with random in_valid gaps (50% duty): the bus shows the three writes in order, each held HOLD_CYCLES cycles. in_ready=0 throughout every ISSUE. done is asserted once.
- Bad checksum: as the single-record case, but CHK=0x0004_0001. Required: the write is still issued; error=1 and stays 1; done never pulses. The next start clears error.
- N=0: COUNT=0, CHK=0. Required: no bus activity; done pulses right after the 4th CHK byte.
- Reset mid-load, plus start while busy: pulse start again during ADDR and observe no effect. Then assert rst during ISSUE. Required: next cycle addr=FFFF_FFFF, busy=0, and the record is not re-issued.
